axis_reg_pipe: RTL and testbench

Parametrised AXI4-Stream register pipeline carrying tdata/tkeep/tlast. It chains STAGES identical register stages so that long routes between the network stack, the memory interfaces and the user kernels can be retimed. Each stage can be configured as a full skid buffer, forward-only, or bypass. The block also exports a live count of beats held inside the pipeline.

---
 rtl/axis_pipe_pkg.sv | 24 ++
 rtl/axis_reg_stage.sv | 103 ++++++++++
 rtl/axis_reg_pipe.sv | 93 +++++++++
 tb/tb_axis_reg_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axis_pipe_pkg
// Brief   : Shared mode encoding and sizing helpers for the AXI4-Stream
//           register pipeline.
// Revision: 1.0 - initial release
// ============================================================================
package axis_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_FWD    = 2'd1,
    MODE_FULL   = 2'd2
  } axis_pipe_mode_t;

  localparam int MAX_STAGES = 8;

  // Width needed to count up to two entries per stage.
  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_reg_stage.sv
`default_nettype none
// ============================================================================
// Module  : axis_reg_stage
// Brief   : One AXI4-Stream register stage, either a two-entry skid buffer
//           or a forward-only register, reporting its entry count.
// Revision: 1.0 - initial release
// ============================================================================
module axis_reg_stage
  import axis_pipe_pkg::*;
#(
  parameter int              PAYLOAD_WIDTH = 577,
  parameter axis_pipe_mode_t MODE          = MODE_FULL
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     i_s_valid,
  output logic                     o_s_ready,
  input  logic [PAYLOAD_WIDTH-1:0] i_s_payload,
  output logic                     o_m_valid,
  input  logic                     i_m_ready,
  output logic [PAYLOAD_WIDTH-1:0] o_m_payload,
  output logic [1:0]               o_count
);

  if (MODE == MODE_FULL) begin : g_full
    logic                     r_main_valid;
    logic                     r_skid_valid;
    logic                     r_ready;
    logic [PAYLOAD_WIDTH-1:0] r_main;
    logic [PAYLOAD_WIDTH-1:0] r_skid;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_load_main;

    assign w_push      = i_s_valid & r_ready;
    assign w_pop       = r_main_valid & i_m_ready;
    assign w_load_main = ~r_main_valid | w_pop;

    // Ready is a flop, so the skid entry absorbs the beat accepted while
    // the downstream stall is still propagating back.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
        r_ready      <= 1'b0;
      end else if (w_load_main) begin
        r_main_valid <= r_skid_valid | w_push;
        r_skid_valid <= 1'b0;
        r_ready      <= 1'b1;
      end else if (w_push) begin
        r_skid_valid <= 1'b1;
        r_ready      <= 1'b0;
      end
    end

    always_ff @(posedge aclk) begin
      if (w_load_main) begin
        r_main <= r_skid_valid ? r_skid : i_s_payload;
      end
      if (!w_load_main && w_push) begin
        r_skid <= i_s_payload;
      end
    end

    assign o_s_ready   = r_ready;
    assign o_m_valid   = r_main_valid;
    assign o_m_payload = r_main;
    assign o_count     = {r_main_valid & r_skid_valid, r_main_valid ^ r_skid_valid};
  end else begin : g_fwd
    logic                     r_valid;
    logic                     r_live;
    logic [PAYLOAD_WIDTH-1:0] r_data;
    logic                     w_ready;

    // r_live holds ready low until the first edge after reset release.
    assign w_ready = r_live & (~r_valid | i_m_ready);

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_valid <= 1'b0;
        r_live  <= 1'b0;
      end else begin
        r_live <= 1'b1;
        if (w_ready) begin
          r_valid <= i_s_valid;
        end
      end
    end

    always_ff @(posedge aclk) begin
      if (w_ready && i_s_valid) begin
        r_data <= i_s_payload;
      end
    end

    assign o_s_ready   = w_ready;
    assign o_m_valid   = r_valid;
    assign o_m_payload = r_data;
    assign o_count     = {1'b0, r_valid};
  end

endmodule
`default_nettype wire

// File: rtl/axis_reg_pipe.sv
`default_nettype none
// ============================================================================
// Module  : axis_reg_pipe
// Brief   : Chain of STAGES AXI4-Stream register stages (skid, forward or
//           bypass) carrying tdata/tkeep/tlast, with a live beat count.
// Revision: 1.0 - initial release
// ============================================================================
module axis_reg_pipe
  import axis_pipe_pkg::*;
#(
  parameter int              DATA_WIDTH = 512,
  parameter int              KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int              STAGES     = 2,
  parameter axis_pipe_mode_t MODE       = MODE_FULL
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]             s_axis_tkeep,
  input  logic                              s_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]             m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic [occ_width(STAGES)-1:0]      occupancy
);

  localparam int c_PW = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam int c_OW = occ_width(STAGES);

  if (MODE == MODE_BYPASS) begin : g_bypass
    assign m_axis_tvalid = s_axis_tvalid;
    assign s_axis_tready = m_axis_tready;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign occupancy     = '0;
  end else begin : g_pipe
    // Each block owns its own link signals so the forward-mode ready chain
    // stays a plain combinational path rather than a self-referencing array.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic            w_s_valid;
      logic            w_s_ready;
      logic [c_PW-1:0] w_s_pay;
      logic            w_m_valid;
      logic            w_m_ready;
      logic [c_PW-1:0] w_m_pay;
      logic [1:0]      w_cnt;
      logic [c_OW-1:0] w_sum;

      if (i == 0) begin : g_head
        assign w_s_valid = s_axis_tvalid;
        assign w_s_pay   = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        assign w_sum     = c_OW'(w_cnt);
      end else begin : g_link
        assign w_s_valid = g_stage[i-1].w_m_valid;
        assign w_s_pay   = g_stage[i-1].w_m_pay;
        assign w_sum     = g_stage[i-1].w_sum + c_OW'(w_cnt);
      end

      if (i == STAGES - 1) begin : g_tail
        assign w_m_ready = m_axis_tready;
      end else begin : g_back
        assign w_m_ready = g_stage[i+1].w_s_ready;
      end

      axis_reg_stage #(
        .PAYLOAD_WIDTH (c_PW),
        .MODE          (MODE)
      ) u_stage (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_s_valid   (w_s_valid),
        .o_s_ready   (w_s_ready),
        .i_s_payload (w_s_pay),
        .o_m_valid   (w_m_valid),
        .i_m_ready   (w_m_ready),
        .o_m_payload (w_m_pay),
        .o_count     (w_cnt)
      );
    end

    assign s_axis_tready = g_stage[0].w_s_ready;
    assign m_axis_tvalid = g_stage[STAGES-1].w_m_valid;
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = g_stage[STAGES-1].w_m_pay;
    assign occupancy     = g_stage[STAGES-1].w_sum;
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_reg_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_axis_reg_pipe
// Brief   : Self-checking bench for axis_reg_pipe in skid, forward and bypass
//           configurations against a beat-queue reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axis_reg_pipe;
  import axis_pipe_pkg::*;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // Skid-buffer instance, STAGES=2
  logic        fl_sv = 0, fl_sr, fl_sl = 0, fl_mv, fl_mr = 0, fl_ml;
  logic [31:0] fl_sd = 0, fl_md;
  logic [3:0]  fl_sk = 0, fl_mk;
  logic [2:0]  fl_occ;
  // Forward-only instance, STAGES=3
  logic        fw_sv = 0, fw_sr, fw_sl = 0, fw_mv, fw_mr = 0, fw_ml;
  logic [31:0] fw_sd = 0, fw_md;
  logic [3:0]  fw_sk = 0, fw_mk;
  logic [2:0]  fw_occ;
  // Bypass instance, DATA_WIDTH=64
  logic        by_sv = 0, by_sr, by_sl = 0, by_mv, by_mr = 0, by_ml;
  logic [63:0] by_sd = 0, by_md;
  logic [7:0]  by_sk = 0, by_mk;
  logic [2:0]  by_occ;

  axis_reg_pipe #(.DATA_WIDTH(32), .STAGES(2), .MODE(MODE_FULL)) u_full (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(fl_sv), .s_axis_tready(fl_sr), .s_axis_tdata(fl_sd),
    .s_axis_tkeep(fl_sk), .s_axis_tlast(fl_sl),
    .m_axis_tvalid(fl_mv), .m_axis_tready(fl_mr), .m_axis_tdata(fl_md),
    .m_axis_tkeep(fl_mk), .m_axis_tlast(fl_ml), .occupancy(fl_occ));

  axis_reg_pipe #(.DATA_WIDTH(32), .STAGES(3), .MODE(MODE_FWD)) u_fwd (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(fw_sv), .s_axis_tready(fw_sr), .s_axis_tdata(fw_sd),
    .s_axis_tkeep(fw_sk), .s_axis_tlast(fw_sl),
    .m_axis_tvalid(fw_mv), .m_axis_tready(fw_mr), .m_axis_tdata(fw_md),
    .m_axis_tkeep(fw_mk), .m_axis_tlast(fw_ml), .occupancy(fw_occ));

  axis_reg_pipe #(.DATA_WIDTH(64), .STAGES(2), .MODE(MODE_BYPASS)) u_byp (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(by_sv), .s_axis_tready(by_sr), .s_axis_tdata(by_sd),
    .s_axis_tkeep(by_sk), .s_axis_tlast(by_sl),
    .m_axis_tvalid(by_mv), .m_axis_tready(by_mr), .m_axis_tdata(by_md),
    .m_axis_tkeep(by_mk), .m_axis_tlast(by_ml), .occupancy(by_occ));

  // Reference model: beats accepted but not yet delivered, in order.
  logic [36:0] flq[$];
  logic [36:0] fwq[$];
  logic        fl_hold = 1'b0;
  logic        fw_hold = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle on the skid instance, entered and left at posedge+1.
  task automatic fl_cycle(input logic sv, input logic [36:0] p, input logic mr,
                          output logic acc, output logic out);
    logic sr0;
    fl_sv = sv; {fl_sl, fl_sk, fl_sd} = p; fl_mr = mr;
    @(negedge aclk);
    chk("fl_occ", 128'(fl_occ), 128'(flq.size()));
    if (fl_hold) chk("fl_hold_valid", 128'(fl_mv), 128'(1));
    if (fl_mv) begin
      if (flq.size() == 0) chk("fl_spurious_valid", 128'(fl_mv), 128'(0));
      else chk("fl_payload", 128'({fl_ml, fl_mk, fl_md}), 128'(flq[0]));
    end
    sr0   = fl_sr;
    fl_mr = ~mr; #1;
    chk("fl_ready_no_comb", 128'(fl_sr), 128'(sr0));
    fl_mr = mr; #1;
    acc     = sv & fl_sr;
    out     = fl_mv & mr;
    fl_hold = fl_mv & ~mr;
    if (out && flq.size() > 0) void'(flq.pop_front());
    if (acc) flq.push_back(p);
    @(posedge aclk); #1;
  endtask

  task automatic fw_cycle(input logic sv, input logic [36:0] p, input logic mr,
                          output logic acc, output logic out, output logic vis);
    fw_sv = sv; {fw_sl, fw_sk, fw_sd} = p; fw_mr = mr;
    @(negedge aclk);
    chk("fw_occ", 128'(fw_occ), 128'(fwq.size()));
    chk("fw_occ_max", 128'(fw_occ <= 3'd3), 128'(1));
    if (fw_hold) chk("fw_hold_valid", 128'(fw_mv), 128'(1));
    if (fw_mv) begin
      if (fwq.size() == 0) chk("fw_spurious_valid", 128'(fw_mv), 128'(0));
      else chk("fw_payload", 128'({fw_ml, fw_mk, fw_md}), 128'(fwq[0]));
    end
    if (fwq.size() == 3) begin
      fw_mr = 1'b0; #1;
      chk("fw_ready_follows_lo", 128'(fw_sr), 128'(0));
      fw_mr = 1'b1; #1;
      chk("fw_ready_follows_hi", 128'(fw_sr), 128'(1));
      fw_mr = mr; #1;
    end
    acc     = sv & fw_sr;
    out     = fw_mv & mr;
    vis     = fw_mv;
    fw_hold = fw_mv & ~mr;
    if (out && fwq.size() > 0) void'(fwq.pop_front());
    if (acc) fwq.push_back(p);
    @(posedge aclk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [36:0] p;
    logic        acc, out, vis, sv;
    int          i, nout, cy, first_acc, first_out, last_out;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_fl_mv", 128'(fl_mv), 128'(0));
    chk("rst_fl_sr", 128'(fl_sr), 128'(0));
    chk("rst_fl_occ", 128'(fl_occ), 128'(0));
    chk("rst_fw_mv", 128'(fw_mv), 128'(0));
    chk("rst_fw_sr", 128'(fw_sr), 128'(0));
    chk("rst_fw_occ", 128'(fw_occ), 128'(0));
    aresetn = 1'b1; #1;
    chk("rel_fl_sr_before_edge", 128'(fl_sr), 128'(0));
    @(posedge aclk); #1;
    chk("rel_fl_sr_after_edge", 128'(fl_sr), 128'(1));
    chk("rel_fw_sr_after_edge", 128'(fw_sr), 128'(1));

    // 1: 16-beat packet, sink always ready
    i = 0; nout = 0; first_acc = -1; first_out = -1; last_out = -1;
    for (int c = 0; c < 200 && nout < 16; c++) begin
      p  = {i == 15, 4'hF, 32'(i)};
      cy = cyc;
      fl_cycle(i < 16, p, 1'b1, acc, out);
      if (acc) begin if (first_acc < 0) first_acc = cy; i++; end
      if (out) begin if (first_out < 0) first_out = cy; last_out = cy; nout++; end
    end
    chk("t1_beats_out", 128'(nout), 128'(16));
    chk("t1_latency", 128'(first_out - first_acc), 128'(2));
    chk("t1_no_bubbles", 128'(last_out - first_out), 128'(15));

    // 2: sink stalled, source offers 10 beats
    i = 0;
    for (int c = 0; c < 12; c++) begin
      p = {i == 9, 4'hF, 32'(100 + i)};
      fl_cycle(i < 10, p, 1'b0, acc, out);
      if (acc) i++;
      chk("t2_ready_vs_fill", 128'(fl_sr), 128'(flq.size() < 4));
    end
    chk("t2_accepted", 128'(i), 128'(4));
    chk("t2_occ_full", 128'(fl_occ), 128'(4));
    nout = 0;
    for (int c = 0; c < 100 && nout < 10; c++) begin
      p = {i == 9, 4'hF, 32'(100 + i)};
      fl_cycle(i < 10, p, 1'b1, acc, out);
      if (acc) i++;
      if (out) nout++;
    end
    chk("t2_delivered", 128'(nout), 128'(10));

    // 3: random traffic, 50% source valid, 30% sink ready
    i = 0; sv = 1'b0;
    for (int c = 0; c < 20000 && i < 2000; c++) begin
      if (!sv) begin
        sv = 1'($urandom_range(0, 1));
        p  = {1'($urandom), 4'($urandom), 32'($urandom)};
      end
      fl_cycle(sv, p, $urandom_range(0, 9) < 3, acc, out);
      if (acc) begin i++; sv = 1'b0; end
    end
    chk("t3_sent", 128'(i), 128'(2000));
    for (int c = 0; c < 50 && flq.size() > 0; c++) fl_cycle(1'b0, p, 1'b1, acc, out);
    chk("t3_model_empty", 128'(flq.size()), 128'(0));
    chk("t3_occ_zero", 128'(fl_occ), 128'(0));

    // 4: forward-only, sink ready 1,0,1,0
    i = 0; nout = 0; first_acc = -1; first_out = -1;
    for (int c = 0; c < 200 && nout < 16; c++) begin
      p  = {i == 15, 4'hF, 32'(200 + i)};
      cy = cyc;
      fw_cycle(i < 16, p, (c % 2) == 0, acc, out, vis);
      if (acc) begin if (first_acc < 0) first_acc = cy; i++; end
      if (vis && first_out < 0) first_out = cy;
      if (out) nout++;
    end
    chk("t4_beats_out", 128'(nout), 128'(16));
    chk("t4_latency", 128'(first_out - first_acc), 128'(3));

    // 5: bypass mirrors inputs in the same cycle
    for (int k = 0; k < 8; k++) begin
      by_sv = 1'($urandom); by_sd = {32'($urandom), 32'($urandom)};
      by_sk = 8'($urandom); by_sl = 1'($urandom); by_mr = 1'($urandom);
      #1;
      chk("t5_valid", 128'(by_mv), 128'(by_sv));
      chk("t5_payload", 128'({by_ml, by_mk, by_md}), 128'({by_sl, by_sk, by_sd}));
      chk("t5_ready", 128'(by_sr), 128'(by_mr));
      chk("t5_occ", 128'(by_occ), 128'(0));
      @(posedge aclk); #1;
    end

    // 6: reset with three beats buffered
    for (int c = 0; c < 3; c++) fl_cycle(1'b1, {1'b0, 4'hF, 32'(300 + c)}, 1'b0, acc, out);
    chk("t6_occ_before", 128'(fl_occ), 128'(3));
    aresetn = 1'b0; #1;
    chk("t6_async_mv", 128'(fl_mv), 128'(0));
    chk("t6_async_occ", 128'(fl_occ), 128'(0));
    chk("t6_async_sr", 128'(fl_sr), 128'(0));
    flq.delete(); fwq.delete(); fl_hold = 1'b0; fw_hold = 1'b0;
    fl_sv = 1'b0; fl_mr = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1; #1;
    chk("t6_sr_before_edge", 128'(fl_sr), 128'(0));
    @(posedge aclk); #1;
    chk("t6_sr_after_edge", 128'(fl_sr), 128'(1));
    i = 0; nout = 0;
    for (int c = 0; c < 50 && nout < 4; c++) begin
      p = {i == 3, 4'hF, 32'(400 + i)};
      fl_cycle(i < 4, p, 1'b1, acc, out);
      if (acc) i++;
      if (out) nout++;
    end
    chk("t6_packet_out", 128'(nout), 128'(4));
    chk("t6_model_empty", 128'(flq.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
